imem_loader: RTL and testbench

Program loader for the single-cycle CPU's instruction memory: the write side of the instruction store. It accepts a program as a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written through a synchronous write port at consecutive word addresses, and the remaining locations are zero-filled. While loading, it holds the CPU via `cpu_hold`, so the CPU only ever fetches a complete image.

---
 rtl/imem_loader_if.sv | 42 ++++
 rtl/imem_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_imem_loader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
//   Bundles the two buses that pass through the program loader.
//   - Byte stream in: byte_in / byte_valid from the host, byte_ready back.
//   - Instruction-memory write port out: imem_we / imem_waddr / imem_wdata.
//   Modports:
//     master : the environment (byte source and instruction memory).
//     slave  : the loader itself.
// ---------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_W = 6
) ();

  // Byte stream from the host.
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;

  // Synchronous write port of the instruction memory.
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  imem_we,
    input  imem_waddr,
    input  imem_wdata
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output imem_we,
    output imem_waddr,
    output imem_wdata
  );

endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Write side of the single-cycle CPU's instruction store. A load request
//   latches a word count; the loader then takes a byte stream, packs every
//   four bytes big-endian into a 32-bit word and writes it at consecutive
//   word addresses starting from 0. Locations above the loaded image are
//   zero-filled so the memory never holds stale code. The CPU is held in
//   reset for the whole load and released only once the image is complete.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   start      in   one-cycle load request, honoured only in IDLE
//   load_len   in   words to load (1..DEPTH), sampled with start
//   bus        --   slave side of imem_loader_if (byte stream + imem write)
//   cpu_hold   out  CPU held in reset while a load is in progress
//   busy       out  loader is not idle
//   done       out  one-cycle pulse when the image is complete
//   err        out  one-cycle pulse after a rejected request
//   checksum   out  XOR of all bytes accepted by the current/last load
//
// All outputs are decoded from flops only; nothing combinational runs from
// an input to an output.
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ADDR_W:0] load_len,
  imem_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [7:0]      checksum
);

  localparam int LEN_W = ADDR_W + 1;

  localparam logic [ADDR_W:0]   DEPTH_LEN = LEN_W'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = LEN_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CLEAR = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // A request is legal only for a non-empty image that fits in memory.
  function automatic logic len_ok(input logic [ADDR_W:0] len);
    return (len != {LEN_W{1'b0}}) && (len <= DEPTH_LEN);
  endfunction

  // Running XOR checksum over the accepted byte stream.
  function automatic logic [7:0] csum_next(input logic [7:0] csum,
                                           input logic [7:0] b);
    return csum ^ b;
  endfunction

  state_e            state_q,    state_d;
  logic [ADDR_W:0]   len_q,      len_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       shift_q,    shift_d;
  logic [7:0]        csum_q,     csum_d;
  logic              err_q,      err_d;

  logic              byte_take;
  logic [ADDR_W:0]   words_written;

  // State and datapath registers; async reset returns every output to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= {LEN_W{1'b0}};
      word_cnt_q <= {LEN_W{1'b0}};
      addr_q     <= {ADDR_W{1'b0}};
      byte_cnt_q <= 2'd0;
      shift_q    <= 32'h0000_0000;
      csum_q     <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      err_q      <= err_d;
    end
  end

  // Next-state and datapath update for the load sequence.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    word_cnt_d    = word_cnt_q;
    addr_d        = addr_q;
    byte_cnt_d    = byte_cnt_q;
    shift_d       = shift_q;
    csum_d        = csum_q;
    err_d         = 1'b0;
    byte_take     = (state_q == S_RECV) && bus.byte_valid;
    words_written = word_cnt_q + CNT_ONE;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok(load_len)) begin
            state_d    = S_RECV;
            len_d      = load_len;
            word_cnt_d = {LEN_W{1'b0}};
            addr_d     = {ADDR_W{1'b0}};
            byte_cnt_d = 2'd0;
            csum_d     = 8'h00;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RECV: begin
        if (byte_take) begin
          // Big-endian packing: the first byte ends up in [31:24].
          shift_d    = {shift_q[23:0], bus.byte_in};
          csum_d     = csum_next(csum_q, bus.byte_in);
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_RECV;
          end
        end else begin
          state_d = S_RECV;
        end
      end

      S_WRITE: begin
        word_cnt_d = words_written;
        if (words_written < len_q) begin
          state_d = S_RECV;
          addr_d  = addr_q + ADDR_ONE;
        end else if (len_q == DEPTH_LEN) begin
          // Full image: the address stays at DEPTH-1 rather than wrapping.
          state_d = S_DONE;
        end else begin
          state_d = S_CLEAR;
          addr_d  = addr_q + ADDR_ONE;
        end
      end

      S_CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CLEAR;
          addr_d  = addr_q + ADDR_ONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the registered state and datapath.
  always_comb begin
    bus.byte_ready = 1'b0;
    bus.imem_we    = 1'b0;
    bus.imem_waddr = addr_q;
    bus.imem_wdata = 32'h0000_0000;
    cpu_hold       = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    err            = err_q;
    checksum       = csum_q;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_RECV: begin
        bus.byte_ready = 1'b1;
        cpu_hold       = 1'b1;
      end
      S_WRITE: begin
        bus.imem_we    = 1'b1;
        bus.imem_wdata = shift_q;
        cpu_hold       = 1'b1;
      end
      S_CLEAR: begin
        // Zero-fill: the data bus keeps its default of zero.
        bus.imem_we = 1'b1;
        cpu_hold    = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader. For each load a timeline of expected
//   outputs is built from the load rules (bytes at one per cycle unless
//   stalled, one write cycle per word, zero-fill to the top, one DONE
//   cycle). A single compare process checks the DUT against that timeline
//   every cycle; literal expectations then pin cycle numbers, data and
//   checksums of the directed scenarios.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int MAXC   = 400;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [ADDR_W:0] load_len;
  logic            cpu_hold;
  logic            busy;
  logic            done;
  logic            err;
  logic [7:0]      checksum;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .load_len (load_len),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  // Expected timeline, indexed by cycle relative to the start cycle.
  logic              e_ready [0:MAXC];
  logic              e_we    [0:MAXC];
  logic              e_hold  [0:MAXC];
  logic              e_busy  [0:MAXC];
  logic              e_done  [0:MAXC];
  logic              e_err   [0:MAXC];
  logic [ADDR_W-1:0] e_addr  [0:MAXC];
  logic [31:0]       e_data  [0:MAXC];
  logic [7:0]        e_csum  [0:MAXC];
  int                pidx    [0:MAXC];
  logic              stall   [0:MAXC];
  logic [7:0]        prog    [0:255];
  int                last_c;
  logic [7:0]        model_cs;

  // Observations gathered by the compare process.
  int          cyc;
  logic        chk_en;
  int          done_seen;
  int          err_seen;
  logic [7:0]  csum_done;
  int          wcyc [0:DEPTH-1];
  logic [31:0] mem  [0:DEPTH-1];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_model(input logic [7:0] prev);
    for (int c = 0; c <= MAXC; c++) begin
      e_ready[c] = 1'b0; e_we[c] = 1'b0; e_hold[c] = 1'b0; e_busy[c] = 1'b0;
      e_done[c]  = 1'b0; e_err[c] = 1'b0; e_addr[c] = '0; e_data[c] = 32'h0;
      e_csum[c]  = prev; pidx[c] = 0;
    end
  endtask

  task automatic clear_stall();
    for (int c = 0; c <= MAXC; c++) stall[c] = 1'b0;
  endtask

  task automatic mark_busy(input int t, input logic [7:0] cs, input int bi);
    e_hold[t] = 1'b1; e_busy[t] = 1'b1; e_csum[t] = cs; pidx[t] = bi;
  endtask

  // Timeline of a legal load of L words starting at cycle 0.
  task automatic build_load(input int L, input logic [7:0] prev);
    int t; int bi; logic [7:0] cs; logic [31:0] word;
    clear_model(prev);
    t = 1; bi = 0; cs = 8'h00;
    for (int w = 0; w < L; w++) begin
      word = 32'h0;
      for (int k = 0; k < 4; k++) begin
        while (stall[t]) begin
          mark_busy(t, cs, bi); e_ready[t] = 1'b1; t++;
        end
        mark_busy(t, cs, bi); e_ready[t] = 1'b1;
        word = {word[23:0], prog[bi]};
        cs   = cs ^ prog[bi];
        bi++; t++;
      end
      mark_busy(t, cs, bi); e_we[t] = 1'b1; e_addr[t] = ADDR_W'(w); e_data[t] = word; t++;
    end
    for (int a = L; a < DEPTH; a++) begin
      mark_busy(t, cs, bi); e_we[t] = 1'b1; e_addr[t] = ADDR_W'(a); e_data[t] = 32'h0; t++;
    end
    e_busy[t] = 1'b1; e_done[t] = 1'b1; e_csum[t] = cs; pidx[t] = bi; t++;
    e_csum[t] = cs; pidx[t] = bi;
    last_c   = t;
    model_cs = cs;
  endtask

  task automatic build_reject(input logic [7:0] prev);
    clear_model(prev);
    e_err[1] = 1'b1;
    last_c   = 3;
    model_cs = prev;
  endtask

  task automatic check_reset_outputs();
    chk("rst_byte_ready", 32'(bus.byte_ready), 32'h0);
    chk("rst_imem_we",    32'(bus.imem_we),    32'h0);
    chk("rst_imem_waddr", 32'(bus.imem_waddr), 32'h0);
    chk("rst_imem_wdata", bus.imem_wdata,      32'h0);
    chk("rst_cpu_hold",   32'(cpu_hold),       32'h0);
    chk("rst_busy",       32'(busy),           32'h0);
    chk("rst_done",       32'(done),           32'h0);
    chk("rst_err",        32'(err),            32'h0);
    chk("rst_checksum",   32'(checksum),       32'h0);
  endtask

  // Drives one request from cycle 0; s1/s2 inject extra start pulses and
  // abort (>0) asserts rst in that cycle.
  task automatic run(input logic [ADDR_W:0] len_in, input int nbytes,
                     input int s1, input int s2, input int abort);
    done_seen = -1; err_seen = -1;
    for (int a = 0; a < DEPTH; a++) begin wcyc[a] = -1; mem[a] = 32'hxxxx_xxxx; end
    @(posedge clk); #1;
    cyc = 0; start = 1'b1; load_len = len_in;
    bus.byte_valid = 1'b0; bus.byte_in = 8'h00; chk_en = 1'b1;
    for (int c = 1; c <= last_c; c++) begin
      @(posedge clk); #1;
      cyc      = c;
      start    = (c == s1) || (c == s2);
      load_len = (c == s1) ? 7'd5 : 7'd0;
      bus.byte_valid = !stall[c];
      bus.byte_in    = (pidx[c] < nbytes) ? prog[pidx[c]] : 8'hA5;
      if (c == abort) begin
        chk_en = 1'b0;
        rst    = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; bus.byte_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    chk_en = 1'b0; start = 1'b0; bus.byte_valid = 1'b0;
  endtask

  // Compare process: DUT outputs against the expected timeline.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("byte_ready", 32'(bus.byte_ready), 32'(e_ready[cyc]));
        chk("imem_we",    32'(bus.imem_we),    32'(e_we[cyc]));
        chk("cpu_hold",   32'(cpu_hold),       32'(e_hold[cyc]));
        chk("busy",       32'(busy),           32'(e_busy[cyc]));
        chk("done",       32'(done),           32'(e_done[cyc]));
        chk("err",        32'(err),            32'(e_err[cyc]));
        chk("checksum",   32'(checksum),       32'(e_csum[cyc]));
        if (e_we[cyc]) begin
          chk("imem_waddr", 32'(bus.imem_waddr), 32'(e_addr[cyc]));
          chk("imem_wdata", bus.imem_wdata,      e_data[cyc]);
        end
        if (bus.imem_we) begin
          wcyc[bus.imem_waddr] = cyc;
          mem[bus.imem_waddr]  = bus.imem_wdata;
        end
        if (done) begin
          done_seen = cyc;
          csum_done = checksum;
        end
        if (err) err_seen = cyc;
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; load_len = '0; chk_en = 1'b0; cyc = 0;
    bus.byte_valid = 1'b0; bus.byte_in = 8'h00;
    clear_stall();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    // L=2, continuous bytes, extra start pulses during RECV.
    prog[0] = 8'h20; prog[1] = 8'h10; prog[2] = 8'h00; prog[3] = 8'h15;
    prog[4] = 8'h20; prog[5] = 8'h11; prog[6] = 8'h00; prog[7] = 8'h17;
    build_load(2, 8'h00);
    run(7'd2, 8, 2, 7, -1);
    chk("l2_done_cycle", 32'(done_seen), 32'd73);
    chk("l2_checksum",   32'(csum_done), 32'h03);  // XOR of the eight bytes
    chk("l2_w0_cycle",   32'(wcyc[0]),   32'd5);
    chk("l2_w1_cycle",   32'(wcyc[1]),   32'd10);
    chk("l2_z2_cycle",   32'(wcyc[2]),   32'd11);
    chk("l2_z63_cycle",  32'(wcyc[63]),  32'd72);
    chk("l2_w0_data",    mem[0],         32'h2010_0015);
    chk("l2_w1_data",    mem[1],         32'h2011_0017);
    chk("l2_z40_data",   mem[40],        32'h0);

    // Rejected requests: zero and oversize lengths.
    build_reject(8'h03);
    run(7'd0, 0, -1, -1, -1);
    chk("rej0_err_cycle", 32'(err_seen), 32'd1);
    build_reject(8'h03);
    run(7'd65, 0, -1, -1, -1);
    chk("rej65_err_cycle", 32'(err_seen), 32'd1);

    // Full image: no zero-fill.
    for (int i = 0; i < 256; i++) prog[i] = 8'(i * 7 + 3);
    build_load(64, 8'h03);
    run(7'd64, 256, -1, -1, -1);
    chk("l64_done_cycle", 32'(done_seen), 32'd321);
    chk("l64_w63_cycle",  32'(wcyc[63]),  32'd320);
    chk("l64_w0_data",    mem[0],         32'h030A_1118);
    chk("l64_w63_data",   mem[63],        32'hE7EE_F5FC);

    // L=4 aborted by reset during the third word.
    for (int i = 0; i < 16; i++) prog[i] = 8'(i * 17 + 5);
    build_load(4, model_cs);
    run(7'd4, 16, -1, -1, 12);

    // L=1 after the abort, with a 3-cycle stall between bytes 2 and 3.
    stall[3] = 1'b1; stall[4] = 1'b1; stall[5] = 1'b1;
    prog[0] = 8'hDE; prog[1] = 8'hAD; prog[2] = 8'hBE; prog[3] = 8'hEF;
    build_load(1, 8'h00);
    run(7'd1, 4, -1, -1, -1);
    clear_stall();
    chk("l1_w0_cycle",   32'(wcyc[0]),   32'd8);
    chk("l1_w0_data",    mem[0],         32'hDEAD_BEEF);
    chk("l1_done_cycle", 32'(done_seen), 32'd72);
    chk("l1_checksum",   32'(csum_done), 32'h22);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
